// File: rtl/ball_motion_engine.sv
// Per-ball fixed-point motion controller: integrate, friction, clamps, collisions, portal, sinking, slingshot aim.
// All outputs registered (one-cycle latency); no backpressure, inputs sampled every cycle.
module ball_motion_engine #(
  parameter int X_INIT          = 280,
  parameter int Y_INIT          = 185,
  parameter int FP_SHIFT        = 6,
  parameter int FRICTION        = 1,
  parameter int MIN_SPEED       = 2,
  parameter int MAX_SPEED       = 230,
  parameter int LEFT_X          = 48,
  parameter int RIGHT_X         = 560,
  parameter int TOP_Y           = 32,
  parameter int BOTTOM_Y        = 416,
  parameter int CUE             = 1,
  parameter int AIM_STEP        = 100,
  parameter int AIM_MAX         = 30,
  parameter int AIM_GAIN        = 10,
  parameter int STOP_FRAMES     = 10,
  parameter int HOLE_FRAMES     = 10,
  parameter int PORTAL_COOLDOWN = 10
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               initialLocation,
  input  logic               aimEnable,
  input  logic               upDirection,
  input  logic               downDirection,
  input  logic               leftDirection,
  input  logic               rightDirection,
  input  logic               enterKey,
  input  logic               collisionBallBorder,
  input  logic [3:0]         HitEdgeCode,
  input  logic               collisionTwoBalls,
  input  logic signed [31:0] xSpeedNew,
  input  logic signed [31:0] ySpeedNew,
  input  logic               inHole,
  input  logic               portalHit,
  input  logic signed [10:0] portalX,
  input  logic signed [10:0] portalY,
  output logic signed [31:0] xSpeed,
  output logic signed [31:0] ySpeed,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [1:0]         state,
  output logic               stopped,
  output logic               killed
);
  localparam int POS_W     = 11 + FP_SHIFT;
  localparam int LEFT_FP   = LEFT_X <<< FP_SHIFT;
  localparam int RIGHT_FP  = RIGHT_X <<< FP_SHIFT;
  localparam int TOP_FP    = TOP_Y <<< FP_SHIFT;
  localparam int BOTTOM_FP = BOTTOM_Y <<< FP_SHIFT;
  localparam logic signed [POS_W-1:0] X_RST = POS_W'(X_INIT <<< FP_SHIFT);
  localparam logic signed [POS_W-1:0] Y_RST = POS_W'(Y_INIT <<< FP_SHIFT);
  localparam logic signed [POS_W-1:0] STEP  = POS_W'(AIM_STEP);
  localparam logic signed [7:0] AIM_LIM = 8'(AIM_MAX);
  localparam logic [7:0] STOP_N = 8'(STOP_FRAMES);
  localparam logic [7:0] HOLE_N = 8'(HOLE_FRAMES);
  localparam logic [7:0] COOL_N = 8'(PORTAL_COOLDOWN);

  typedef enum logic [1:0] {REST = 2'd0, ROLL = 2'd1, AIM = 2'd2, SUNK = 2'd3} state_t;

  state_t                  state_q, state_d;
  logic signed [POS_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d, xanc_q, xanc_d, yanc_q, yanc_d;
  logic signed [31:0]      xspd_q, xspd_d, yspd_q, yspd_d;
  logic signed [7:0]       xaim_q, xaim_d, yaim_q, yaim_d;
  logic [7:0]              stop_q, stop_d, hole_q, hole_d, cool_q, cool_d, hole_nxt;
  logic                    ball_hit_q, ball_hit_d, border_hit_q, border_hit_d;
  logic                    stopped_q, stopped_d, killed_q, killed_d;
  logic                    ball_ev, border_ev, portal_ev;

  function automatic logic signed [31:0] clamp_spd(input logic signed [31:0] v);
    if (v > MAX_SPEED) return MAX_SPEED;
    if (v < -MAX_SPEED) return -MAX_SPEED;
    return v;
  endfunction

  function automatic logic signed [31:0] friction(input logic signed [31:0] v);
    if (v >= MIN_SPEED) return v - FRICTION;
    if (v <= -MIN_SPEED) return v + FRICTION;
    return '0;
  endfunction

  function automatic logic signed [POS_W-1:0] step_pos(input logic signed [POS_W-1:0] p,
                                                       input logic signed [31:0] v,
                                                       input int lo, input int hi);
    logic signed [31:0] s;
    s = 32'(p) + v;
    if (s < lo) s = lo;
    else if (s > hi) s = hi;
    return POS_W'(s);
  endfunction

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= REST;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      xpos_q <= X_RST;  ypos_q <= Y_RST;  xanc_q <= X_RST;  yanc_q <= Y_RST;
      xspd_q <= '0;     yspd_q <= '0;     xaim_q <= '0;     yaim_q <= '0;
      stop_q <= '0;     hole_q <= '0;     cool_q <= '0;
      ball_hit_q <= 1'b0; border_hit_q <= 1'b0;
      stopped_q  <= 1'b1; killed_q     <= 1'b0;
    end else begin
      xpos_q <= xpos_d;  ypos_q <= ypos_d;  xanc_q <= xanc_d;  yanc_q <= yanc_d;
      xspd_q <= xspd_d;  yspd_q <= yspd_d;  xaim_q <= xaim_d;  yaim_q <= yaim_d;
      stop_q <= stop_d;  hole_q <= hole_d;  cool_q <= cool_d;
      ball_hit_q <= ball_hit_d; border_hit_q <= border_hit_d;
      stopped_q  <= stopped_d;  killed_q     <= killed_d;
    end
  end

  always_comb begin
    state_d = state_q;  xpos_d = xpos_q;  ypos_d = ypos_q;  xanc_d = xanc_q;  yanc_d = yanc_q;
    xspd_d = xspd_q;    yspd_d = yspd_q;  xaim_d = xaim_q;  yaim_d = yaim_q;
    stop_d = stop_q;    hole_d = hole_q;  cool_d = cool_q;
    ball_hit_d = ball_hit_q; border_hit_d = border_hit_q;
    stopped_d = stopped_q;   killed_d = killed_q;
    ball_ev = 1'b0; border_ev = 1'b0; portal_ev = 1'b0; hole_nxt = hole_q;
    if (initialLocation) begin
      state_d = REST;  xpos_d = X_RST;  ypos_d = Y_RST;  xspd_d = '0;  yspd_d = '0;
      xaim_d = '0;  yaim_d = '0;  stop_d = '0;  hole_d = '0;  cool_d = '0;
      ball_hit_d = 1'b0;  border_hit_d = 1'b0;  stopped_d = 1'b1;  killed_d = 1'b0;
    end else begin
      case (state_q)
        SUNK: begin
          xspd_d = '0;  yspd_d = '0;  killed_d = 1'b1;  stopped_d = 1'b1;
        end
        AIM: if (startOfFrame) begin
          if (!aimEnable) begin
            xpos_d = xanc_q;  ypos_d = yanc_q;  xaim_d = '0;  yaim_d = '0;  state_d = REST;
          end else if (enterKey) begin
            xspd_d = clamp_spd(32'(xaim_q) * AIM_GAIN);
            yspd_d = clamp_spd(32'(yaim_q) * AIM_GAIN);
            xaim_d = '0;  yaim_d = '0;  state_d = ROLL;  stopped_d = 1'b0;
          end else begin
            // Slingshot: pulling the ball one way loads speed in the opposite direction.
            if (upDirection && yaim_d < AIM_LIM)      begin yaim_d = yaim_d + 8'sd1; ypos_d = ypos_d - STEP; end
            if (downDirection && yaim_d > -AIM_LIM)   begin yaim_d = yaim_d - 8'sd1; ypos_d = ypos_d + STEP; end
            if (leftDirection && xaim_d < AIM_LIM)    begin xaim_d = xaim_d + 8'sd1; xpos_d = xpos_d - STEP; end
            if (rightDirection && xaim_d > -AIM_LIM)  begin xaim_d = xaim_d - 8'sd1; xpos_d = xpos_d + STEP; end
          end
        end
        default: begin
          if (startOfFrame) hole_nxt = inHole ? hole_q + 8'd1 : 8'd0;
          if (hole_nxt == HOLE_N) begin
            state_d = SUNK;  xspd_d = '0;  yspd_d = '0;  killed_d = 1'b1;  stopped_d = 1'b1;
            hole_d = '0;  stop_d = '0;
          end else begin
            hole_d  = hole_nxt;
            ball_ev = collisionTwoBalls && !ball_hit_q;
            if (ball_ev) begin
              xspd_d = clamp_spd(xSpeedNew);  yspd_d = clamp_spd(ySpeedNew);  ball_hit_d = 1'b1;
            end
            if (state_q == REST) begin
              if (xspd_d != 0 || yspd_d != 0) begin
                state_d = ROLL;  stopped_d = 1'b0;
              end else if (CUE != 0 && aimEnable) begin
                state_d = AIM;  xanc_d = xpos_q;  yanc_d = ypos_q;
              end
              if (startOfFrame) begin ball_hit_d = ball_ev; border_hit_d = 1'b0; end
            end else begin
              border_ev = collisionBallBorder && !border_hit_q;
              if (border_ev) begin
                // Corner codes always carry one x-edge and one y-edge bit, so per-axis tests cover them.
                if (HitEdgeCode[1] || HitEdgeCode[3]) xspd_d = -xspd_d;
                if (HitEdgeCode[0] || HitEdgeCode[2]) yspd_d = -yspd_d;
                border_hit_d = 1'b1;
              end
              portal_ev = portalHit && (cool_q == 8'd0);
              if (portal_ev) begin
                xpos_d = POS_W'(32'(portalX) <<< FP_SHIFT);
                ypos_d = POS_W'(32'(portalY) <<< FP_SHIFT);
                cool_d = COOL_N;
              end
              if (startOfFrame) begin
                if (!portal_ev) begin
                  xpos_d = step_pos(xpos_q, xspd_q, LEFT_FP, RIGHT_FP);
                  ypos_d = step_pos(ypos_q, yspd_q, TOP_FP, BOTTOM_FP);
                  if (cool_q != 8'd0) cool_d = cool_q - 8'd1;
                end
                if (!ball_ev && !border_ev) begin
                  xspd_d = friction(xspd_q);  yspd_d = friction(yspd_q);
                end
                ball_hit_d = ball_ev;  border_hit_d = border_ev;
                if (xspd_q == 0 && yspd_q == 0 && !ball_ev) begin
                  if (stop_q + 8'd1 == STOP_N) begin
                    state_d = REST;  stopped_d = 1'b1;  stop_d = '0;
                  end else begin
                    stop_d = stop_q + 8'd1;
                  end
                end else begin
                  stop_d = '0;
                end
              end
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    xSpeed   = xspd_q;
    ySpeed   = yspd_q;
    topLeftX = xpos_q[POS_W-1:FP_SHIFT];
    topLeftY = ypos_q[POS_W-1:FP_SHIFT];
    state    = state_q;
    stopped  = stopped_q;
    killed   = killed_q;
  end
endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine: expected values queued with each stimulus step, popped at the check.
module tb_ball_motion_engine;
  logic clk = 1'b0;
  logic resetN, startOfFrame, initialLocation, aimEnable;
  logic upDirection, downDirection, leftDirection, rightDirection, enterKey;
  logic collisionBallBorder, collisionTwoBalls, inHole, portalHit;
  logic [3:0] HitEdgeCode;
  logic signed [31:0] xSpeedNew, ySpeedNew, xSpeed, ySpeed;
  logic signed [10:0] portalX, portalY, topLeftX, topLeftY;
  logic [1:0] state;
  logic stopped, killed;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string             tag;
    logic signed [63:0] val;
  } exp_t;
  exp_t sb[$];

  ball_motion_engine dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .initialLocation(initialLocation),
    .aimEnable(aimEnable), .upDirection(upDirection), .downDirection(downDirection),
    .leftDirection(leftDirection), .rightDirection(rightDirection), .enterKey(enterKey),
    .collisionBallBorder(collisionBallBorder), .HitEdgeCode(HitEdgeCode),
    .collisionTwoBalls(collisionTwoBalls), .xSpeedNew(xSpeedNew), .ySpeedNew(ySpeedNew),
    .inHole(inHole), .portalHit(portalHit), .portalX(portalX), .portalY(portalY),
    .xSpeed(xSpeed), .ySpeed(ySpeed), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .state(state), .stopped(stopped), .killed(killed)
  );

  always #5 clk = ~clk;

  task automatic sb_push(input string tag, input logic signed [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic signed [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_init();
    initialLocation = 1'b1;
    @(negedge clk);
    initialLocation = 1'b0;
  endtask

  task automatic pulse_ball(input int vx, input int vy);
    xSpeedNew = vx;
    ySpeedNew = vy;
    collisionTwoBalls = 1'b1;
    @(negedge clk);
    collisionTwoBalls = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; initialLocation = 1'b0; aimEnable = 1'b0;
    upDirection = 1'b0; downDirection = 1'b0; leftDirection = 1'b0; rightDirection = 1'b0;
    enterKey = 1'b0; collisionBallBorder = 1'b0; collisionTwoBalls = 1'b0; inHole = 1'b0;
    portalHit = 1'b0; HitEdgeCode = 4'b0000; xSpeedNew = 0; ySpeedNew = 0; portalX = 0; portalY = 0;
    repeat (2) @(negedge clk);
    sb_push("rst_state", 0); sb_push("rst_stopped", 1); sb_push("rst_killed", 0);
    sb_push("rst_x", 280);   sb_push("rst_y", 185);     sb_push("rst_xspd", 0);
    sb_check(state); sb_check(stopped); sb_check(killed);
    sb_check(topLeftX); sb_check(topLeftY); sb_check(xSpeed);
    resetN = 1'b1;
    @(negedge clk);

    // Roll decay from a ball hit of +10
    sb_push("decay_state", 1); sb_push("decay_xspd0", 10); sb_push("decay_stopped", 0);
    pulse_ball(10, 0);
    sb_check(state); sb_check(xSpeed); sb_check(stopped);
    for (int k = 1; k <= 10; k++) begin
      sb_push($sformatf("decay_xspd_f%0d", k), 10 - k);
      frame();
      sb_check(xSpeed);
    end
    sb_push("decay_x", 280);
    sb_check(topLeftX);
    frames(9);
    sb_push("decay_roll_f19", 1);
    sb_check(state);
    frame();
    sb_push("decay_rest_f20", 0); sb_push("decay_stopped_f20", 1);
    sb_check(state); sb_check(stopped);

    // Border reflection, held pulses, and combined collision
    pulse_ball(40, 20);
    HitEdgeCode = 4'b0010; collisionBallBorder = 1'b1;
    repeat (2) @(negedge clk);
    collisionBallBorder = 1'b0;
    sb_push("border_r_x", -40); sb_push("border_r_y", 20);
    sb_check(xSpeed); sb_check(ySpeed);
    frame();
    HitEdgeCode = 4'b0011; collisionBallBorder = 1'b1;
    repeat (2) @(negedge clk);
    collisionBallBorder = 1'b0;
    sb_push("border_corner_x", 39); sb_push("border_corner_y", -19);
    sb_check(xSpeed); sb_check(ySpeed);
    frame();
    HitEdgeCode = 4'b0100; collisionBallBorder = 1'b1;
    pulse_ball(50, -60);
    collisionBallBorder = 1'b0;
    sb_push("both_x", 50); sb_push("both_y", 60);
    sb_check(xSpeed); sb_check(ySpeed);
    pulse_init();
    sb_push("init_state", 0); sb_push("init_x", 280); sb_push("init_xspd", 0);
    sb_check(state); sb_check(topLeftX); sb_check(xSpeed);

    // Aim and release
    aimEnable = 1'b1;
    @(negedge clk);
    sb_push("aim_state", 2);
    sb_check(state);
    leftDirection = 1'b1;
    frames(3);
    sb_push("aim_x", 275);
    sb_check(topLeftX);
    enterKey = 1'b1;
    frame();
    enterKey = 1'b0; leftDirection = 1'b0; aimEnable = 1'b0;
    sb_push("rel_xspd", 30); sb_push("rel_yspd", 0); sb_push("rel_state", 1);
    sb_check(xSpeed); sb_check(ySpeed); sb_check(state);
    pulse_init();

    // Aim then cancel restores anchor
    aimEnable = 1'b1;
    @(negedge clk);
    upDirection = 1'b1;
    frames(2);
    upDirection = 1'b0;
    sb_push("aim_y", 181);
    sb_check(topLeftY);
    aimEnable = 1'b0;
    frame();
    sb_push("cancel_y", 185); sb_push("cancel_x", 280); sb_push("cancel_state", 0);
    sb_check(topLeftY); sb_check(topLeftX); sb_check(state);

    // Aim counter saturation and clamped release
    aimEnable = 1'b1;
    @(negedge clk);
    rightDirection = 1'b1;
    frames(32);
    sb_push("aimsat_x", 326);
    sb_check(topLeftX);
    enterKey = 1'b1;
    frame();
    enterKey = 1'b0; rightDirection = 1'b0; aimEnable = 1'b0;
    sb_push("aimsat_xspd", -230);
    sb_check(xSpeed);
    pulse_init();

    // Speed saturation, portal, cooldown and right clamp
    sb_push("sat_xspd", 230);
    pulse_ball(500, 0);
    sb_check(xSpeed);
    portalX = 11'sd550; portalY = 11'sd210; portalHit = 1'b1;
    @(negedge clk);
    portalHit = 1'b0;
    sb_push("portal_x", 550); sb_push("portal_y", 210); sb_push("portal_xspd", 230);
    sb_check(topLeftX); sb_check(topLeftY); sb_check(xSpeed);
    frame();
    sb_push("roll_x_f1", 553);
    sb_check(topLeftX);
    portalX = 11'sd100; portalY = 11'sd100; portalHit = 1'b1;
    @(negedge clk);
    portalHit = 1'b0;
    sb_push("portal_cool_x", 553); sb_push("portal_cool_y", 210);
    sb_check(topLeftX); sb_check(topLeftY);
    frame();
    sb_push("roll_x_f2", 557);
    sb_check(topLeftX);
    frame();
    sb_push("clamp_right_x", 560);
    sb_check(topLeftX);

    // Sinking, then recovery
    inHole = 1'b1;
    frames(9);
    sb_push("hole_f9_state", 1);
    sb_check(state);
    frame();
    sb_push("sunk_state", 3); sb_push("sunk_killed", 1); sb_push("sunk_stopped", 1); sb_push("sunk_xspd", 0);
    sb_check(state); sb_check(killed); sb_check(stopped); sb_check(xSpeed);
    inHole = 1'b0;
    pulse_ball(77, 0);
    frame();
    sb_push("sunk_ignore_xspd", 0); sb_push("sunk_ignore_state", 3);
    sb_check(xSpeed); sb_check(state);
    pulse_init();
    sb_push("unsink_state", 0); sb_push("unsink_killed", 0);
    sb_push("unsink_x", 280);   sb_push("unsink_y", 185);
    sb_check(state); sb_check(killed); sb_check(topLeftX); sb_check(topLeftY);

    // Asynchronous reset while aiming
    aimEnable = 1'b1;
    @(negedge clk);
    leftDirection = 1'b1;
    frame();
    sb_push("aimr_x", 278); sb_push("aimr_state", 2);
    sb_check(topLeftX); sb_check(state);
    resetN = 1'b0;
    #1;
    sb_push("areset_state", 0); sb_push("areset_x", 280); sb_push("areset_stopped", 1);
    sb_check(state); sb_check(topLeftX); sb_check(stopped);
    aimEnable = 1'b0; leftDirection = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
